// File: rtl/fb_ring_controller.sv
// N-bank frame-buffer ring: pixel writer, display reader and background clear engine.
// Bank roles rotate FREE -> WRITING -> PENDING -> DISPLAY -> CLEARING -> FREE.
module fb_ring_controller #(
  parameter  int unsigned NUM_BUF   = 3,
  parameter  int unsigned PIX_W     = 4,
  parameter  int unsigned H_RES     = 640,
  parameter  int unsigned V_RES     = 480,
  parameter  int unsigned CLEAR_VAL = 0,
  localparam int unsigned PIX_COUNT = H_RES * V_RES,
  localparam int unsigned ADDR_W    = $clog2(PIX_COUNT),
  localparam int unsigned BUF_W     = $clog2(NUM_BUF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              wr_done,
  output logic              wr_ready,
  input  logic              frame_start,
  input  logic              rd_en,
  input  logic [9:0]        rd_row,
  input  logic [9:0]        rd_col,
  output logic [PIX_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic [BUF_W-1:0]  disp_buf,
  output logic              swap,
  output logic [7:0]        drop_cnt,
  output logic              err
);

  localparam logic [PIX_W-1:0] CLEAR_PIX = PIX_W'(CLEAR_VAL);

  typedef enum logic [2:0] {
    R_FREE,
    R_CLEARING,
    R_WRITING,
    R_PENDING,
    R_DISPLAY
  } role_t;

  role_t              role [NUM_BUF];

  logic [ADDR_W-1:0]  clr_cnt;
  logic               clr_active;
  logic [BUF_W-1:0]   clr_buf;

  logic               has_writing, has_pending, has_free, has_clearing;
  logic [BUF_W-1:0]   wr_idx, pend_idx, free_idx, clr_low;

  logic               clr_go, clr_last;
  logic [BUF_W-1:0]   clr_cur;
  logic               wr_fire, wr_done_ok, swap_ok;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_in_range;
  logic [PIX_W-1:0]   bank_q [NUM_BUF];

  // Role decode: unique roles report their bank; FREE/CLEARING report the lowest index.
  always_comb begin
    has_writing  = 1'b0;
    has_pending  = 1'b0;
    has_free     = 1'b0;
    has_clearing = 1'b0;
    wr_idx       = '0;
    pend_idx     = '0;
    free_idx     = '0;
    clr_low      = '0;
    for (int unsigned i = 0; i < NUM_BUF; i++) begin
      case (role[i])
        R_WRITING: begin
          has_writing = 1'b1;
          wr_idx      = BUF_W'(i);
        end
        R_PENDING: begin
          has_pending = 1'b1;
          pend_idx    = BUF_W'(i);
        end
        R_FREE: begin
          if (!has_free) begin
            has_free = 1'b1;
            free_idx = BUF_W'(i);
          end
        end
        R_CLEARING: begin
          if (!has_clearing) begin
            has_clearing = 1'b1;
            clr_low      = BUF_W'(i);
          end
        end
        default: ;
      endcase
    end
  end

  // The clear engine latches its bank so a lower bank entering CLEARING mid-sweep waits its turn.
  assign clr_go     = clr_active | has_clearing;
  assign clr_cur    = clr_active ? clr_buf : clr_low;
  assign clr_last   = (clr_cnt == ADDR_W'(PIX_COUNT - 1));

  assign wr_fire    = wr_en & has_writing & (32'(wr_addr) < PIX_COUNT);
  assign wr_done_ok = wr_done & has_writing;
  assign swap_ok    = frame_start & has_pending;

  assign rd_addr     = ADDR_W'(32'(rd_row) * H_RES + 32'(rd_col));
  assign rd_in_range = (32'(rd_row) < V_RES) && (32'(rd_col) < H_RES);

  for (genvar b = 0; b < NUM_BUF; b++) begin : g_bank
    logic [PIX_W-1:0] mem [PIX_COUNT];

    always_ff @(posedge clk) begin
      if (clr_go && clr_cur == BUF_W'(b)) begin
        mem[clr_cnt] <= CLEAR_PIX;
      end else if (wr_fire && wr_idx == BUF_W'(b)) begin
        mem[wr_addr] <= wr_data;
      end
    end

    assign bank_q[b] = mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_BUF; i++) begin
        role[i] <= (i == 0) ? R_DISPLAY : R_CLEARING;
      end
      clr_cnt    <= '0;
      clr_active <= 1'b0;
      clr_buf    <= '0;
      wr_ready   <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      disp_buf   <= '0;
      swap       <= 1'b0;
      drop_cnt   <= '0;
      err        <= 1'b0;
    end else begin
      if (clr_go) begin
        if (clr_last) begin
          role[clr_cur] <= R_FREE;
          clr_cnt       <= '0;
          clr_active    <= 1'b0;
        end else begin
          clr_cnt       <= clr_cnt + ADDR_W'(1);
          clr_active    <= 1'b1;
          clr_buf       <= clr_cur;
        end
      end

      if (!has_writing && has_free) begin
        role[free_idx] <= R_WRITING;
      end

      if (swap_ok) begin
        role[disp_buf] <= R_CLEARING;
        role[pend_idx] <= R_DISPLAY;
        disp_buf       <= pend_idx;
      end
      swap <= swap_ok;

      // A simultaneous swap consumes the old pending frame, so only a lone wr_done drops it.
      if (wr_done_ok) begin
        role[wr_idx] <= R_PENDING;
        if (has_pending && !frame_start) begin
          role[pend_idx] <= R_CLEARING;
          if (drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
          end
        end
      end

      wr_ready <= has_writing ? !wr_done : has_free;

      if ((wr_en || wr_done) && !wr_ready) begin
        err <= 1'b1;
      end

      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_in_range ? bank_q[disp_buf] : '0;
      end
    end
  end

endmodule

// File: tb/tb_fb_ring_controller.sv
// Testbench for fb_ring_controller: directed scenarios with randomized pixels and reads,
// checked every cycle against a bank-index level reference model.
module tb_fb_ring_controller;

  localparam int NB = 3;
  localparam int HR = 8;
  localparam int VR = 4;
  localparam int PC = HR * VR;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_done;
  logic       wr_ready;
  logic       frame_start;
  logic       rd_en;
  logic [9:0] rd_row;
  logic [9:0] rd_col;
  logic [3:0] rd_data;
  logic       rd_valid;
  logic [1:0] disp_buf;
  logic       swap;
  logic [7:0] drop_cnt;
  logic       err;

  fb_ring_controller #(
    .NUM_BUF(NB),
    .PIX_W(4),
    .H_RES(HR),
    .V_RES(VR),
    .CLEAR_VAL(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_done(wr_done),
    .wr_ready(wr_ready),
    .frame_start(frame_start),
    .rd_en(rd_en),
    .rd_row(rd_row),
    .rd_col(rd_col),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .disp_buf(disp_buf),
    .swap(swap),
    .drop_cnt(drop_cnt),
    .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: banks tracked by the index holding each unique role plus FREE/CLEARING sets.
  int         m_disp, m_pend, m_writ, m_clr_cur, m_clr_pos, m_drop;
  bit         m_clr [NB];
  bit         m_free [NB];
  bit         m_known [NB];
  logic [3:0] m_mem [NB][PC];
  bit         m_swap, m_err, m_rd_valid, m_rd_known;
  logic [3:0] m_rd_data;

  bit         rnd_rd;
  logic [3:0] frm [PC];
  logic [3:0] frm_a [PC];
  logic [3:0] exp_frm [PC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input bit s [NB]);
    for (int i = 0; i < NB; i++) if (s[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_disp = 0; m_pend = -1; m_writ = -1;
    m_clr_cur = -1; m_clr_pos = 0; m_drop = 0;
    for (int i = 0; i < NB; i++) begin
      m_clr[i]  = (i != 0);
      m_free[i] = 1'b0;
    end
    m_swap = 0; m_err = 0; m_rd_valid = 0; m_rd_known = 1; m_rd_data = '0;
  endtask

  task automatic model_step();
    int o_disp, o_pend, o_writ, lf;
    o_disp = m_disp; o_pend = m_pend; o_writ = m_writ;
    lf = lowest(m_free);
    m_rd_valid = rd_en;
    if (rd_en) begin
      if (rd_row < VR && rd_col < HR) begin
        m_rd_data  = m_mem[o_disp][rd_row * HR + rd_col];
        m_rd_known = m_known[o_disp];
      end else begin
        m_rd_data  = '0;
        m_rd_known = 1;
      end
    end
    if ((wr_en || wr_done) && o_writ < 0) m_err = 1;
    if (wr_en && o_writ >= 0 && int'(wr_addr) < PC) m_mem[o_writ][wr_addr] = wr_data;
    if (m_clr_cur < 0) m_clr_cur = lowest(m_clr);
    if (m_clr_cur >= 0) begin
      m_mem[m_clr_cur][m_clr_pos] = '0;
      m_clr_pos++;
      if (m_clr_pos == PC) begin
        m_clr[m_clr_cur] = 0; m_free[m_clr_cur] = 1; m_known[m_clr_cur] = 1;
        m_clr_cur = -1; m_clr_pos = 0;
      end
    end
    if (o_writ < 0 && lf >= 0) begin
      m_writ = lf; m_free[lf] = 0;
    end
    m_swap = 0;
    if (frame_start && o_pend >= 0) begin
      m_clr[o_disp] = 1; m_disp = o_pend; m_pend = -1; m_swap = 1;
    end
    if (wr_done && o_writ >= 0) begin
      if (o_pend >= 0 && !frame_start) begin
        m_clr[o_pend] = 1;
        if (m_drop < 255) m_drop++;
      end
      m_pend = o_writ; m_writ = -1;
    end
  endtask

  task automatic check_all();
    chk("wr_ready", 32'(wr_ready), 32'(m_writ >= 0));
    chk("disp_buf", 32'(disp_buf), 32'(m_disp));
    chk("swap", 32'(swap), 32'(m_swap));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("err", 32'(err), 32'(m_err));
    chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
    if (m_rd_valid && m_rd_known) chk("rd_data", 32'(rd_data), 32'(m_rd_data));
  endtask

  task automatic cycle();
    if (rnd_rd) begin
      rd_en  = 1'($urandom % 2);
      rd_row = 10'($urandom_range(0, 5));
      rd_col = 10'($urandom_range(0, 9));
    end
    @(posedge clk);
    model_step();
    #1;
    check_all();
    wr_en = 0; wr_done = 0; frame_start = 0; rd_en = 0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!wr_ready && n < 200) begin
      cycle();
      n++;
    end
    chk("wait_ready", 32'(wr_ready), 32'd1);
  endtask

  // Writes a random frame into the WRITING bank; frm holds its expected contents.
  task automatic write_frame(input bit with_fs);
    int nw;
    wait_ready();
    for (int p = 0; p < PC; p++) frm[p] = '0;
    nw = $urandom_range(4, 10);
    for (int k = 0; k < nw; k++) begin
      wr_en   = 1;
      wr_addr = 5'($urandom_range(0, PC - 1));
      wr_data = 4'($urandom);
      frm[wr_addr] = wr_data;
      cycle();
    end
    wr_done = 1;
    frame_start = with_fs;
    cycle();
  endtask

  task automatic read_frame(input string tag);
    for (int p = 0; p < PC; p++) begin
      rd_en  = 1;
      rd_row = 10'(p / HR);
      rd_col = 10'(p % HR);
      cycle();
      chk(tag, 32'(rd_data), 32'(exp_frm[p]));
    end
  endtask

  task automatic release_and_time(input string tag);
    int n = 0;
    rst_n = 1;
    while (!wr_ready && n < 100) begin
      cycle();
      n++;
    end
    chk(tag, n, 33);
  endtask

  initial begin
    int d0, a;
    rst_n = 0; wr_en = 0; wr_addr = '0; wr_data = '0; wr_done = 0;
    frame_start = 0; rd_en = 0; rd_row = '0; rd_col = '0; rnd_rd = 0;
    for (int b = 0; b < NB; b++) begin
      m_known[b] = 1'b0;
      for (int p = 0; p < PC; p++) m_mem[b][p] = '0;
    end
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_all();

    // Scenario 1: wr_ready latency after reset release, with random reads running.
    rnd_rd = 1;
    release_and_time("ready_latency");

    // Scenario 2: single pixel frame, swap, read back.
    rnd_rd = 0;
    for (int k = 0; k < 3; k++) begin
      do a = $urandom_range(0, PC - 1); while (a == 5);
      wr_en = 1; wr_addr = 5'(a); wr_data = 4'($urandom); cycle();
    end
    wr_en = 1; wr_addr = 5'd5; wr_data = 4'hA; cycle();
    wr_done = 1; cycle();
    chk("ready_after_done", 32'(wr_ready), 32'd0);
    frame_start = 1; cycle();
    chk("first_swap", 32'(swap), 32'd1);
    chk("first_disp", 32'(disp_buf), 32'd1);
    cycle();
    chk("swap_one_shot", 32'(swap), 32'd0);
    rd_en = 1; rd_row = 10'd0; rd_col = 10'd5; cycle();
    chk("read_0xA", 32'(rd_data), 32'hA);
    chk("read_0xA_valid", 32'(rd_valid), 32'd1);
    rd_en = 1; rd_row = 10'd4; rd_col = 10'd1; cycle();
    chk("oob_row_data", 32'(rd_data), 32'd0);
    rd_en = 1; rd_row = 10'd0; rd_col = 10'd8; cycle();
    chk("oob_col_valid", 32'(rd_valid), 32'd1);

    // Scenario 3: three frames with no scan-out swap.
    rnd_rd = 1;
    d0 = drop_cnt;
    repeat (3) write_frame(0);
    chk("drop_after_3", 32'(drop_cnt), 32'(d0 + 2));
    chk("err_clean", 32'(err), 32'd0);
    rnd_rd = 0;
    for (int p = 0; p < PC; p++) exp_frm[p] = frm[p];
    frame_start = 1; cycle();
    chk("swap_last_frame", 32'(swap), 32'd1);
    read_frame("last_frame_px");

    // Scenario 4: writes while no WRITING bank.
    rnd_rd = 1;
    write_frame(0);
    rnd_rd = 0;
    for (int p = 0; p < PC; p++) exp_frm[p] = frm[p];
    chk("ready_low_window", 32'(wr_ready), 32'd0);
    for (int k = 0; k < 5 && !wr_ready; k++) begin
      wr_en = 1; wr_addr = 5'($urandom); wr_data = 4'($urandom); cycle();
    end
    chk("err_set", 32'(err), 32'd1);
    repeat (3) cycle();
    chk("err_sticky", 32'(err), 32'd1);
    frame_start = 1; cycle();
    read_frame("unchanged_px");

    // Scenario 5: wr_done and frame_start together while a frame is pending.
    rnd_rd = 1;
    write_frame(0);
    for (int p = 0; p < PC; p++) frm_a[p] = frm[p];
    d0 = drop_cnt;
    write_frame(1);
    chk("coinc_swap", 32'(swap), 32'd1);
    chk("coinc_drop", 32'(drop_cnt), 32'(d0));
    rnd_rd = 0;
    for (int p = 0; p < PC; p++) exp_frm[p] = frm_a[p];
    read_frame("coinc_old_px");
    for (int p = 0; p < PC; p++) exp_frm[p] = frm[p];
    frame_start = 1; cycle();
    chk("coinc_next_swap", 32'(swap), 32'd1);
    read_frame("coinc_new_px");

    // Scenario 6: asynchronous reset mid-clear during a write.
    rnd_rd = 1;
    write_frame(0);
    frame_start = 1; cycle();
    repeat (3) begin
      wr_en = 1; wr_addr = 5'($urandom); wr_data = 4'($urandom); cycle();
    end
    wr_en = 1; wr_addr = 5'($urandom); wr_data = 4'($urandom);
    rnd_rd = 0;
    #3;
    rst_n = 0;
    #1;
    chk("arst_wr_ready", 32'(wr_ready), 32'd0);
    chk("arst_rd_data", 32'(rd_data), 32'd0);
    chk("arst_rd_valid", 32'(rd_valid), 32'd0);
    chk("arst_disp_buf", 32'(disp_buf), 32'd0);
    chk("arst_swap", 32'(swap), 32'd0);
    chk("arst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    model_reset();
    wr_en = 0;
    repeat (2) @(posedge clk);
    #1;
    rnd_rd = 1;
    release_and_time("ready_latency_again");
    write_frame(0);
    frame_start = 1; cycle();
    repeat (40) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
